// File: rtl/regfile_writeback_pkg.sv
// Shared widths and the write-back request type for the register-file write side.
package regfile_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/regfile_writeback_if.sv
// Pipeline-side bundle of regfile_writeback: issue, ALU, load, source query, write port.
// REGFILE_WB_BYPASS_EN adds the forwarding outputs rs1_fwd, rs2_fwd and fwd_data.
interface regfile_writeback_if;
  import regfile_pkg::*;

  logic              issue_valid;
  logic [REG_AW-1:0] issue_rd;
  logic              issue_ready;
  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_rd;
  logic [XLEN-1:0]   ld_data;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              rs1_busy;
  logic              rs2_busy;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   d;
  logic              we_reg;
`ifdef REGFILE_WB_BYPASS_EN
  logic              rs1_fwd;
  logic              rs2_fwd;
  logic [XLEN-1:0]   fwd_data;
`endif

  modport master (
    output issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
           ld_valid, ld_rd, ld_data, rs1, rs2,
    input  issue_ready, ld_ready, rs1_busy, rs2_busy, rd, d, we_reg
`ifdef REGFILE_WB_BYPASS_EN
    , input rs1_fwd, rs2_fwd, fwd_data
`endif
  );

  modport slave (
    input  issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
           ld_valid, ld_rd, ld_data, rs1, rs2,
    output issue_ready, ld_ready, rs1_busy, rs2_busy, rd, d, we_reg
`ifdef REGFILE_WB_BYPASS_EN
    , output rs1_fwd, rs2_fwd, fwd_data
`endif
  );
endinterface

// File: rtl/regfile_writeback_wb_fifo.sv
// Synchronous FIFO of write-back requests (power-of-two depth) buffering load results.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_req_t                push_data,
  input  logic                   pop,
  output wb_req_t                head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  wb_req_t       mem_q [DEPTH];
  wb_req_t       mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Next-state for storage, pointers and occupancy; pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {(REG_AW + XLEN){1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == {(AW+1){1'b0}});
  assign count = count_q;
endmodule

// File: rtl/regfile_writeback.sv
// Register-file write front end: ALU/load merge onto one write port plus RAW pending scoreboard.
// Optional REGFILE_WB_BYPASS_EN forwards the value being written to a source whose last write is landing.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int LD_FIFO_DEPTH = 4,
  parameter int PEND_W        = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_writeback_if.slave  bus
);
  localparam int                CNT_W    = $clog2(LD_FIFO_DEPTH) + 1;
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_0   = {PEND_W{1'b0}};
  localparam logic [REG_AW-1:0] X0       = {REG_AW{1'b0}};

  wb_req_t           fifo_head, ld_req, sel_req;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CNT_W-1:0]  fifo_count;
  logic              ld_ready, ld_push, ld_bypass, sel_valid;
  logic              we_q, we_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   d_q, d_d;
  logic [PEND_W-1:0] pend_q [NUM_REGS];
  logic [PEND_W-1:0] pend_d [NUM_REGS];
  logic              retire, issue_ready, issue_fire, rs1_busy, rs2_busy;
`ifdef REGFILE_WB_BYPASS_EN
  logic              rs1_fwd, rs2_fwd;
`endif

  wb_fifo #(.DEPTH(LD_FIFO_DEPTH)) u_ld_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(ld_req),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Arbitration: ALU first, then FIFO head, then a load passing straight through an empty FIFO.
  always_comb begin
    ld_req.rd   = bus.ld_rd;
    ld_req.data = bus.ld_data;
    ld_ready    = (fifo_count != CNT_W'(LD_FIFO_DEPTH));
    ld_push     = bus.ld_valid && ld_ready;
    ld_bypass   = ld_push && fifo_empty && !bus.alu_valid;
    fifo_push   = ld_push && !ld_bypass && !fifo_full;
    fifo_pop    = !bus.alu_valid && !fifo_empty;
    sel_valid   = 1'b0;
    sel_req     = {(REG_AW + XLEN){1'b0}};
    if (bus.alu_valid) begin
      sel_valid    = 1'b1;
      sel_req.rd   = bus.alu_rd;
      sel_req.data = bus.alu_data;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_req   = fifo_head;
    end else if (ld_bypass) begin
      sel_valid = 1'b1;
      sel_req   = ld_req;
    end else begin
      sel_valid = 1'b0;
    end
    we_d = sel_valid && (sel_req.rd != X0);
    rd_d = sel_req.rd;
    d_d  = sel_req.data;
  end

  // Pending counters: a same-cycle issue and retire on one register cancel out.
  always_comb begin
    retire      = we_q && (rd_q != X0);
    issue_ready = (bus.issue_rd == X0) || (pend_q[bus.issue_rd] != PEND_MAX) ||
                  (retire && (rd_q == bus.issue_rd));
    issue_fire  = bus.issue_valid && issue_ready && (bus.issue_rd != X0);
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_d[i] = pend_q[i];
      if (issue_fire && (bus.issue_rd == REG_AW'(i)) && !(retire && (rd_q == REG_AW'(i)))) begin
        pend_d[i] = pend_q[i] + PEND_ONE;
      end else if (retire && (rd_q == REG_AW'(i)) && !(issue_fire && (bus.issue_rd == REG_AW'(i))) &&
                   (pend_q[i] != PEND_0)) begin
        pend_d[i] = pend_q[i] - PEND_ONE;
      end else begin
        pend_d[i] = pend_q[i];
      end
    end
  end

  // Source-busy query for decode.
  always_comb begin
`ifdef REGFILE_WB_BYPASS_EN
    rs1_fwd  = we_q && (rd_q == bus.rs1) && (bus.rs1 != X0) && (pend_q[bus.rs1] == PEND_ONE);
    rs2_fwd  = we_q && (rd_q == bus.rs2) && (bus.rs2 != X0) && (pend_q[bus.rs2] == PEND_ONE);
    rs1_busy = (bus.rs1 != X0) && (pend_q[bus.rs1] != PEND_0) && !rs1_fwd;
    rs2_busy = (bus.rs2 != X0) && (pend_q[bus.rs2] != PEND_0) && !rs2_fwd;
`else
    rs1_busy = (bus.rs1 != X0) && (pend_q[bus.rs1] != PEND_0);
    rs2_busy = (bus.rs2 != X0) && (pend_q[bus.rs2] != PEND_0);
`endif
  end

  // Write-port and scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
      rd_q <= {REG_AW{1'b0}};
      d_q  <= {XLEN{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
        pend_q[i] <= PEND_0;
      end
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      d_q    <= d_d;
      pend_q <= pend_d;
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.ld_ready    = ld_ready;
  assign bus.rs1_busy    = rs1_busy;
  assign bus.rs2_busy    = rs2_busy;
  assign bus.rd          = rd_q;
  assign bus.d           = d_q;
  assign bus.we_reg      = we_q;
`ifdef REGFILE_WB_BYPASS_EN
  assign bus.rs1_fwd     = rs1_fwd;
  assign bus.rs2_fwd     = rs2_fwd;
  assign bus.fwd_data    = d_q;
`endif
endmodule
